// File: rtl/shift_pkg.sv
// shift_pkg: shared types and defaults for the sequential left shifter.
//  state_t     FSM states ST_IDLE -> ST_SHIFT -> ST_DONE
//  OP_SLL/ROL  op port encodings (rotate only with LEFTSHIFT_ROTATE_EN)
//  DEF_*       default operand and shift-amount widths
package shift_pkg;

  localparam int unsigned DEF_WIDTH   = 32;
  localparam int unsigned DEF_SHAMT_W = 5;

  localparam logic OP_SLL = 1'b0;
  localparam logic OP_ROL = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/leftshiftn.sv
// leftshiftn: combinational fixed left shift by N with zero fill.
// Optional macro LEFTSHIFT_ROTATE_EN: rot=1 turns the stage into a rotate left by N.
// Ports:
//  a    in   WIDTH  operand
//  rot  in   1      rotate select (ignored unless LEFTSHIFT_ROTATE_EN)
//  y    out  WIDTH  shifted/rotated result
module leftshiftn #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned N     = 1
) (
  input  logic [WIDTH-1:0] a,
  input  logic             rot,
  output logic [WIDTH-1:0] y
);

`ifdef LEFTSHIFT_ROTATE_EN
  // Bits pushed off the top re-enter at the bottom.
  assign y = rot ? ((a << N) | (a >> (WIDTH - N))) : (a << N);
`else
  logic unused_rot;
  assign unused_rot = rot;
  assign y = a << N;
`endif

endmodule

// File: rtl/leftshift_seq.sv
// leftshift_seq: multi-cycle logical left shifter (SLL/SLLV path).
// One power-of-two stage per clock: stage k applies a shift by 1<<k when
// bit k of the shift amount is set. Fixed latency of SHAMT_W cycles.
// Optional macro LEFTSHIFT_ROTATE_EN: op=1 selects rotate left; when the
// macro is undefined, op is ignored and every request is a logical shift.
// Ports:
//  clk, rst             clock; synchronous active-high reset
//  in_valid, in_ready   request handshake (in_ready high only in idle)
//  a, b, op             operand, shift amount, operation
//  out_valid, out_ready result handshake
//  out                  result, stable while out_valid is high
module leftshift_seq
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH   = DEF_WIDTH,
  parameter int unsigned SHAMT_W = DEF_SHAMT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [SHAMT_W-1:0] b,
  input  logic               op,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out
);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [SHAMT_W-1:0] amt_q, amt_d;
  logic [SHAMT_W-1:0] k_q, k_d;
  logic               rot;

`ifdef LEFTSHIFT_ROTATE_EN
  logic opr_q, opr_d;
  assign rot = (opr_q == OP_ROL);
`else
  logic unused_op;
  assign unused_op = op;
  assign rot       = 1'b0;
`endif

  // One-hot stage select derived from the stage counter.
  logic [SHAMT_W-1:0] sel;
  assign sel = SHAMT_W'(1) << k_q;

  logic [WIDTH-1:0] stage_out [SHAMT_W];
  logic [WIDTH-1:0] stage_sel;

  for (genvar g = 0; g < SHAMT_W; g++) begin : g_stage
    leftshiftn #(
      .WIDTH (WIDTH),
      .N     (1 << g)
    ) u_stage (
      .a   (acc_q),
      .rot (rot),
      .y   (stage_out[g])
    );
  end

  always_comb begin
    stage_sel = acc_q;
    for (int unsigned i = 0; i < SHAMT_W; i++) begin
      if (sel[i]) stage_sel = stage_out[i];
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    amt_d   = amt_q;
    k_d     = k_q;
`ifdef LEFTSHIFT_ROTATE_EN
    opr_d   = opr_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          acc_d   = a;
          amt_d   = b;
          k_d     = '0;
`ifdef LEFTSHIFT_ROTATE_EN
          opr_d   = op;
`endif
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (|(amt_q & sel)) acc_d = stage_sel;
        k_d = k_q + SHAMT_W'(1);
        if (k_q == SHAMT_W'(SHAMT_W - 1)) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      amt_q   <= '0;
      k_q     <= '0;
`ifdef LEFTSHIFT_ROTATE_EN
      opr_q   <= OP_SLL;
`endif
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      amt_q   <= amt_d;
      k_q     <= k_d;
`ifdef LEFTSHIFT_ROTATE_EN
      opr_q   <= opr_d;
`endif
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign out       = acc_q;

endmodule

// File: tb/tb_leftshift_seq.sv
module tb_leftshift_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [4:0]  b;
  logic        op;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  leftshift_seq u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: shift into a double-width word; rotate folds the spill back in.
  function automatic logic [31:0] ref_model(logic [31:0] av, logic [4:0] bv, logic opv);
    logic [63:0] w;
    logic [31:0] r;
    w = {32'b0, av} << bv;
    r = w[31:0];
`ifdef LEFTSHIFT_ROTATE_EN
    if (opv) r = w[31:0] | w[63:32];
`else
    if (opv) r = w[31:0];
`endif
    return r;
  endfunction

  // One transaction: accept, measure latency, optional output stall, drain.
  task automatic run_txn(input logic [31:0] av, input logic [4:0] bv, input logic opv,
                         input int stall, input bit poke, input string tag);
    logic [31:0] exp;
    int cyc;
    int lat;
    exp = ref_model(av, bv, opv);
    out_ready = (stall == 0);
    cyc = 0;
    while (!in_ready && cyc < 20) begin
      tick();
      cyc++;
    end
    check({tag, "_idle_ready"}, 32'(in_ready), 32'd1);
    a = av;
    b = bv;
    op = opv;
    in_valid = 1'b1;
    tick();
    in_valid = poke;
    a = $urandom;
    b = 5'($urandom);
    op = 1'($urandom);
    lat = 0;
    while (!out_valid && lat < 20) begin
      check({tag, "_busy_ready"}, 32'(in_ready), 32'd0);
      tick();
      lat++;
    end
    in_valid = 1'b0;
    check({tag, "_latency"}, 32'(lat), 32'd5);
    check({tag, "_result"}, out, exp);
    for (int i = 0; i < stall; i++) begin
      tick();
      check({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
      check({tag, "_hold_out"}, out, exp);
      check({tag, "_hold_ready"}, 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    tick();
    check({tag, "_drain_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_drain_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    int cyc;
    bit stray;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
    op = 1'b0;
    tick();
    tick();
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out", out, 32'd0);
    rst = 1'b0;

    run_txn(32'h0000_0001, 5'd5, 1'b0, 0, 1'b0, "t1");
    run_txn(32'hFFFF_FFFF, 5'd31, 1'b0, 0, 1'b0, "t2_b31");
    run_txn(32'h1234_5678, 5'd0, 1'b0, 0, 1'b0, "t2_b0");
    run_txn(32'hA5A5_0F0F, 5'd7, 1'b0, 10, 1'b0, "t3_stall");
    run_txn(32'h0000_00FF, 5'd12, 1'b0, 0, 1'b1, "t4_poke");

    // Reset in the third shift cycle discards the request.
    out_ready = 1'b1;
    a = 32'hDEAD_BEEF;
    b = 5'd3;
    op = 1'b0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5_out_valid", 32'(out_valid), 32'd0);
    check("t5_out", out, 32'd0);
    check("t5_in_ready", 32'(in_ready), 32'd1);
    stray = 1'b0;
    for (cyc = 0; cyc < 10; cyc++) begin
      tick();
      if (out_valid) stray = 1'b1;
    end
    check("t5_no_stale", 32'(stray), 32'd0);

`ifdef LEFTSHIFT_ROTATE_EN
    run_txn(32'h8000_0001, 5'd4, 1'b1, 0, 1'b0, "t6_rol");
    check("t6_rol_const", out, 32'h0000_0018);
    run_txn(32'h8000_0001, 5'd4, 1'b0, 0, 1'b0, "t6_sll");
    check("t6_sll_const", out, 32'h0000_0010);
`else
    run_txn(32'h8000_0001, 5'd4, 1'b1, 0, 1'b0, "t6_op_ignored");
    check("t6_op_ignored_const", out, 32'h0000_0010);
`endif

    for (int n = 0; n < 40; n++) begin
      run_txn($urandom, 5'($urandom), 1'($urandom), int'($urandom_range(0, 3)),
              1'($urandom), "rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
